core_mem_sequencer: RTL and testbench
=====================================

// Module: core_mem_sequencer
// PURPOSE
// Multi-cycle sequencer that lets the single-cycle RV32 core share one single-port memory for fetch and load/store.
// Steps the core with a one-cycle commit enable. Fetches the instruction, then performs at most one data access,
// then commits. Sits between the core top level and the unified memory; detects bus timeout and misalignment.
// PARAMETERS
// N        32  datapath/address width
// TIMEOUT  15  max cycles waiting for mem_ack before bus error (1..255)
// PORTS
// clk          in   1  system clock, rising edge
// reset        in   1  asynchronous, active-low reset
// run          in   1  1 = keep executing; 0 = stop after current instruction commits
// pc_addr      in   N  core PC (fetch address)
// dmem_addr    in   N  core ALU result (load/store address)
// dmem_wdata   in   N  core rs2 data (store data)
// dmem_read    in   1  core load request (combinational from decoded instruction)
// dmem_write   in   1  core store request
// instruction  out  32 registered instruction presented to core
// dmem_rdata   out  N  registered load data presented to core
// core_step    out  1  one-cycle enable: core commits PC/register file this cycle
// mem_req      out  1  memory request, held until mem_ack
// mem_we       out  1  1 = write
// mem_addr     out  N  memory address
// mem_wdata    out  N  memory write data
// mem_ack      in   1  memory completion; may assert in the same cycle as mem_req
// mem_rdata    in   N  read data, valid when mem_ack=1
// busy         out  1  state != IDLE and != HALT
// err          out  2  sticky: bit0 bus timeout, bit1 misaligned address/illegal request
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE; instruction=32'h0000_0013 (NOP); dmem_rdata=0; core_step=0; mem_req=0;
//   mem_we=0; mem_addr=0; mem_wdata=0; err=0; timer=0. Reset mid-access drops mem_req at once; nothing commits.
// - States: IDLE, FETCH, DECODE, DATA, COMMIT, HALT.
// - IDLE: run=1 -> FETCH.
// - FETCH: mem_req=1, mem_we=0, mem_addr=pc_addr. On mem_ack: instruction<=mem_rdata -> DECODE.
//   pc_addr[1:0]!=0 -> err[1]<=1, no request -> HALT.
// - DECODE: one settle cycle, mem_req=0. dmem_read|dmem_write -> DATA, else -> COMMIT.
//   dmem_read&dmem_write -> err[1]<=1 -> HALT.
// - DATA: mem_req=1, mem_addr=dmem_addr, mem_we=dmem_write, mem_wdata=dmem_wdata. dmem_addr[1:0]!=0 -> err[1], HALT.
//   On mem_ack: load -> dmem_rdata<=mem_rdata; -> COMMIT.
// - COMMIT: core_step=1 for exactly one cycle; run=1 -> FETCH, run=0 -> IDLE.
// - HALT: all requests low, core_step=0; exit only by reset.
// - mem_addr/mem_we/mem_wdata are registered at state entry. They stay stable while mem_req=1.
//   mem_req deasserts the cycle after mem_ack.
// - Timer: counts while mem_req=1 and mem_ack=0; clears on ack or state change. At TIMEOUT: err[0]<=1, req dropped, HALT.
// - Latency, ack in the same cycle as req: ALU/branch instruction = 3 cycles (FETCH, DECODE, COMMIT); load/store = 4.
//   Each ack-wait cycle adds 1.
// - instruction/dmem_rdata hold until overwritten, so core combinational inputs are stable through COMMIT.
// - run dropped mid-instruction: current instruction completes and commits, then IDLE.
// - err bits are sticky; cleared only by reset.
// STRUCTURE
// - core_mem_pkg: state_t enum, NOP_INSTR=32'h0000_0013, ERR_TIMEOUT/ERR_ALIGN bit indices.
// - Sub-module mem_ack_timer (clear, enable, expired; TIMEOUT param). FSM plus output registers in this module.
// TESTING
// - reset=0 then 1 with run=0 -> instruction=0x00000013, core_step=0, mem_req=0, busy=0 indefinitely.
// - run=1, zero-wait memory, pc=0x0, mem_rdata=0x00500093 (addi), no dmem -> core_step pulses every 3rd cycle;
//   mem_we never 1.
// - Store: dmem_write=1, dmem_addr=0x100, dmem_wdata=0xDEADBEEF -> write req with those values in DATA;
//   core_step 1 cycle after ack; 4-cycle period.
// - Load with ack delayed 3 cycles, mem_rdata=0x12345678 -> req/addr stable 4 cycles; dmem_rdata=0x12345678
//   before core_step; 7-cycle period.
// - mem_ack held 0 -> mem_req drops after 15 wait cycles, err=2'b01, HALT, core_step never asserted; reset clears err.
// - pc_addr=0x2 -> err=2'b10, no mem_req issued. Separately, reset asserted mid-DATA -> mem_req=0 immediately,
//   no core_step.

Source files
------------

// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core/memory sequencer.
package core_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_DATA,
        ST_COMMIT,
        ST_HALT
    } state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          ERR_TIMEOUT = 0;
    localparam int          ERR_ALIGN   = 1;

endpackage

// File: rtl/core_mem_sequencer_if.sv
// Single-port memory bus shared by instruction fetch and load/store.
interface core_mem_sequencer_if #(
    parameter int N = 32
);
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         mem_ack;
    logic [N-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_ack_timer.sv
// Counts cycles spent waiting for a memory acknowledge; flags expiry on
// the TIMEOUT-th consecutive wait cycle.
module mem_ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] count;

    // Wait-cycle counter: clear has priority so a new request starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // count holds the number of wait cycles already elapsed before this one.
    assign expired = enable && (count == 8'(TIMEOUT - 1));
endmodule

// File: rtl/core_mem_sequencer.sv
// Multi-cycle sequencer letting a single-cycle RV32 core share one memory
// port for fetch and load/store; steps the core with a one-cycle commit.
module core_mem_sequencer
    import core_mem_pkg::*;
#(
    parameter int N       = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [N-1:0]        pc_addr,
    input  logic [N-1:0]        dmem_addr,
    input  logic [N-1:0]        dmem_wdata,
    input  logic                dmem_read,
    input  logic                dmem_write,
    output logic [31:0]         instruction,
    output logic [N-1:0]        dmem_rdata,
    output logic                core_step,
    output logic                busy,
    output logic [1:0]          err,
    core_mem_sequencer_if.master mem
);
    state_t       state, state_n;
    logic [1:0]   err_set;
    logic         req_q, we_q;
    logic [N-1:0] addr_q, wdata_q;
    logic         fetch_req, req_any, timer_clear, timer_expired;

    // The core PC only changes on core_step, so it is stable for the whole
    // FETCH state; it is used directly because a copy taken while leaving
    // COMMIT would still hold the pre-commit PC.
    assign fetch_req = (state == ST_FETCH) && (pc_addr[1:0] == 2'b00);
    assign req_any   = fetch_req || req_q;

    assign mem.mem_req   = req_any;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = (state == ST_FETCH) ? pc_addr : addr_q;
    assign mem.mem_wdata = wdata_q;

    assign busy = (state != ST_IDLE) && (state != ST_HALT);
    assign err  = err_q_out();

    logic [1:0] err_q;
    function automatic logic [1:0] err_q_out();
        return err_q;
    endfunction

    assign timer_clear = (state_n != state) || mem.mem_ack;

    mem_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (req_any && !mem.mem_ack),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and error detection.
    always_comb begin
        state_n = state;
        err_set = 2'b00;
        case (state)
            ST_IDLE: begin
                if (run) state_n = ST_FETCH;
            end
            ST_FETCH: begin
                if (pc_addr[1:0] != 2'b00) begin
                    err_set[ERR_ALIGN] = 1'b1;
                    state_n            = ST_HALT;
                end else if (mem.mem_ack) begin
                    state_n = ST_DECODE;
                end else if (timer_expired) begin
                    err_set[ERR_TIMEOUT] = 1'b1;
                    state_n              = ST_HALT;
                end
            end
            ST_DECODE: begin
                // Core decode outputs have settled from the registered
                // instruction, so the data request is checked before issue.
                if (dmem_read && dmem_write) begin
                    err_set[ERR_ALIGN] = 1'b1;
                    state_n            = ST_HALT;
                end else if (dmem_read || dmem_write) begin
                    if (dmem_addr[1:0] != 2'b00) begin
                        err_set[ERR_ALIGN] = 1'b1;
                        state_n            = ST_HALT;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else begin
                    state_n = ST_COMMIT;
                end
            end
            ST_DATA: begin
                if (mem.mem_ack) begin
                    state_n = ST_COMMIT;
                end else if (timer_expired) begin
                    err_set[ERR_TIMEOUT] = 1'b1;
                    state_n              = ST_HALT;
                end
            end
            ST_COMMIT: begin
                state_n = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_n = ST_HALT;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Output registers: request/address captured on entry to DATA, read
    // data captured on acknowledge, errors accumulated until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= NOP_INSTR;
            dmem_rdata  <= '0;
            core_step   <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 2'b00;
        end else begin
            core_step <= (state_n == ST_COMMIT);
            req_q     <= (state_n == ST_DATA);
            if ((state == ST_DECODE) && (state_n == ST_DATA)) begin
                addr_q  <= dmem_addr;
                we_q    <= dmem_write;
                wdata_q <= dmem_wdata;
            end else if (state_n != ST_DATA) begin
                we_q <= 1'b0;
            end
            if (fetch_req && mem.mem_ack) begin
                instruction <= mem.mem_rdata[31:0];
            end
            if ((state == ST_DATA) && mem.mem_ack && !we_q) begin
                dmem_rdata <= mem.mem_rdata;
            end
            err_q <= err_q | err_set;
        end
    end
endmodule

// File: tb/tb_core_mem_sequencer.sv
// Randomized and directed bench for core_mem_sequencer with a
// transaction-level memory/core reference model.
module tb_core_mem_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] pc_addr, dmem_addr, dmem_wdata;
    logic        dmem_read, dmem_write;
    logic [31:0] instruction, dmem_rdata;
    logic        core_step, busy;
    logic [1:0]  err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem_arr [256];
    logic [31:0] ref_arr [256];

    core_mem_sequencer_if #(.N(32)) mem_bus ();

    core_mem_sequencer #(.N(32), .TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .pc_addr     (pc_addr),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_read   (dmem_read),
        .dmem_write  (dmem_write),
        .instruction (instruction),
        .dmem_rdata  (dmem_rdata),
        .core_step   (core_step),
        .busy        (busy),
        .err         (err),
        .mem         (mem_bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction from its FETCH cycle to its COMMIT cycle. kind: 0 ALU,
    // 1 load, 2 store. Expected period = fetch(1+waits) + decode + data(1+waits) + commit.
    task automatic run_instr(input int kind, input logic [31:0] pc, input logic [31:0] daddr,
                             input logic [31:0] wd, input int fwait, input int dwait,
                             input bit drop_run);
        int period, cyc, waited, phase;
        bit stepped;
        logic [31:0] exp_instr, exp_load;
        exp_instr = ref_arr[pc[9:2]];
        exp_load  = ref_arr[daddr[9:2]];
        period    = 3 + fwait + ((kind != 0) ? (dwait + 1) : 0);
        if (kind == 2) ref_arr[daddr[9:2]] = wd;
        pc_addr    = pc;
        dmem_addr  = daddr;
        dmem_wdata = wd;
        dmem_read  = (kind == 1);
        dmem_write = (kind == 2);
        run        = 1'b1;
        cyc = 0; waited = 0; phase = 0; stepped = 0;
        while (!stepped && cyc < 64) begin
            tick();
            cyc++;
            if (drop_run && cyc == 2) run = 1'b0;
            mem_bus.mem_ack = 1'b0;
            chk("busy", {31'b0, busy}, 32'd1);
            if (mem_bus.mem_req) begin
                if (phase == 0) begin
                    chk("fetch_addr", mem_bus.mem_addr, pc);
                    chk("fetch_we", {31'b0, mem_bus.mem_we}, 32'd0);
                end else begin
                    chk("data_addr", mem_bus.mem_addr, daddr);
                    chk("data_we", {31'b0, mem_bus.mem_we}, {31'b0, kind == 2});
                    if (kind == 2) chk("data_wdata", mem_bus.mem_wdata, wd);
                end
                if (waited == ((phase == 0) ? fwait : dwait)) begin
                    mem_bus.mem_ack = 1'b1;
                    if (mem_bus.mem_we) mem_arr[mem_bus.mem_addr[9:2]] = mem_bus.mem_wdata;
                    else mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr[9:2]];
                    waited = 0;
                    phase++;
                end else begin
                    waited++;
                    mem_bus.mem_rdata = $urandom;
                end
            end
            if (core_step) begin
                stepped = 1;
                chk("period", cyc, period);
                chk("instruction", instruction, exp_instr);
                if (kind == 1) chk("load_data", dmem_rdata, exp_load);
            end
        end
        if (!stepped) chk("commit_seen", 32'd0, 32'd1);
        mem_bus.mem_ack = 1'b0;
    endtask

    initial begin
        int n_req;
        bit stepped_bad;
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            mem_arr[i] = v;
            ref_arr[i] = v;
        end
        reset = 1'b0; run = 1'b0;
        pc_addr = '0; dmem_addr = '0; dmem_wdata = '0; dmem_read = 0; dmem_write = 0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", instruction, 32'h0000_0013);
        chk("rst_rdata", dmem_rdata, 32'd0);
        chk("rst_addr", mem_bus.mem_addr, 32'd0);
        chk("rst_wdata", mem_bus.mem_wdata, 32'd0);
        chk("rst_err", {30'b0, err}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("idle_instr", instruction, 32'h0000_0013);
            chk("idle_ctl", {28'b0, core_step, mem_bus.mem_req, mem_bus.mem_we, busy}, 32'd0);
        end

        // Back-to-back ALU instructions at zero wait.
        mem_arr[0] = 32'h0050_0093; ref_arr[0] = 32'h0050_0093;
        for (int i = 0; i < 5; i++) run_instr(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);

        // Store then load back, then a slow load of a known word.
        run_instr(2, 32'h4, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
        run_instr(1, 32'h8, 32'h100, 32'h0, 0, 0, 0);
        mem_arr[32'h104 >> 2] = 32'h1234_5678; ref_arr[32'h104 >> 2] = 32'h1234_5678;
        run_instr(1, 32'hC, 32'h104, 32'h0, 0, 3, 0);

        // Random instruction mix with random wait states.
        for (int i = 0; i < 40; i++) begin
            run_instr($urandom_range(0, 2), {22'b0, 8'($urandom_range(0, 255)), 2'b00},
                      {22'b0, 8'($urandom_range(0, 255)), 2'b00}, $urandom,
                      $urandom_range(0, 4), $urandom_range(0, 4), 0);
        end

        // run dropped mid-instruction: it commits, then the sequencer idles.
        run_instr(1, 32'h10, 32'h20, 32'h0, 1, 1, 1);
        tick();
        chk("drop_idle", {30'b0, busy, mem_bus.mem_req}, 32'd0);
        tick();
        chk("drop_idle2", {30'b0, busy, core_step}, 32'd0);
        run_instr(0, 32'h14, 32'h0, 32'h0, 0, 0, 0);

        // Memory never acknowledges.
        pc_addr = 32'h20; dmem_read = 0; dmem_write = 0;
        n_req = 0; stepped_bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            mem_bus.mem_ack = 1'b0;
            if (mem_bus.mem_req) n_req++;
            if (core_step) stepped_bad = 1;
        end
        chk("timeout_reqs", n_req, 32'd15);
        chk("timeout_err", {30'b0, err}, 32'd1);
        chk("timeout_halt", {30'b0, busy, stepped_bad}, 32'd0);
        reset = 1'b0;
        #1;
        chk("reset_clear_err", {30'b0, err}, 32'd0);
        tick();
        reset = 1'b1;

        // Misaligned PC.
        run = 1'b1; pc_addr = 32'h2; n_req = 0; stepped_bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_bus.mem_req) n_req++;
            if (core_step) stepped_bad = 1;
        end
        chk("misalign_reqs", n_req, 32'd0);
        chk("misalign_err", {30'b0, err}, 32'd2);
        chk("misalign_halt", {30'b0, busy, stepped_bad}, 32'd0);

        // Reset asserted while a load waits in DATA.
        reset = 1'b0;
        tick();
        reset = 1'b1; run = 1'b0;
        tick();
        pc_addr = 32'h10; dmem_addr = 32'h40; dmem_read = 1; run = 1'b1;
        tick();
        chk("mid_fetch_req", {31'b0, mem_bus.mem_req}, 32'd1);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0000_0003;
        tick();
        mem_bus.mem_ack = 1'b0;
        chk("mid_decode_req", {31'b0, mem_bus.mem_req}, 32'd0);
        tick();
        chk("mid_data_addr", mem_bus.mem_addr, 32'h40);
        chk("mid_data_req", {31'b0, mem_bus.mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_reset_req", {30'b0, mem_bus.mem_req, core_step}, 32'd0);
        run = 1'b0;
        tick();
        reset = 1'b1;
        stepped_bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (core_step) stepped_bad = 1;
        end
        chk("mid_reset_nostep", {31'b0, stepped_bad}, 32'd0);

        // Simultaneous load and store request.
        pc_addr = 32'h0; dmem_read = 1; dmem_write = 1; run = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = mem_arr[0];
        tick();
        mem_bus.mem_ack = 1'b0;
        tick();
        chk("rw_err", {30'b0, err}, 32'd2);
        chk("rw_halt", {29'b0, busy, mem_bus.mem_req, core_step}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
